// File: rtl/utf8_pkg.sv
// ============================================================================
//  Module      : utf8_pkg
//  Description : Shared constants, types and helpers for the UTF-8 encoder
//                and its code-point classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package utf8_pkg;

    // Sequence length encoded as (number of bytes - 1)
    typedef logic [1:0] len_t;

    localparam len_t LEN_1 = 2'd0;
    localparam len_t LEN_2 = 2'd1;
    localparam len_t LEN_3 = 2'd2;
    localparam len_t LEN_4 = 2'd3;

    localparam logic [1:0] STATUS_IDLE  = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;
    localparam logic [1:0] STATUS_ERROR = 2'b10;

    localparam logic [20:0] MAX_1BYTE        = 21'h00007F;
    localparam logic [20:0] MAX_2BYTE        = 21'h0007FF;
    localparam logic [20:0] MAX_3BYTE        = 21'h00FFFF;
    localparam logic [20:0] MAX_CODE_POINT   = 21'h10FFFF;
    localparam logic [20:0] SURROGATE_LO     = 21'h00D800;
    localparam logic [20:0] SURROGATE_HI     = 21'h00DFFF;
    localparam logic [20:0] REPLACEMENT_CHAR = 21'h00FFFD;

    localparam logic [7:0] LEAD_2      = 8'hC0;
    localparam logic [7:0] LEAD_3      = 8'hE0;
    localparam logic [7:0] LEAD_4      = 8'hF0;
    localparam logic [1:0] CONT_PREFIX = 2'b10;

    // Continuation byte still owed when 'remaining' bytes are left; the
    // highest-order 6-bit group goes out first.
    function automatic logic [7:0] cont_byte(input logic [17:0] cp,
                                             input len_t        remaining);
        logic [7:0] result;
        case (remaining)
            LEN_4:   result = {CONT_PREFIX, cp[17:12]};
            LEN_3:   result = {CONT_PREFIX, cp[11:6]};
            default: result = {CONT_PREFIX, cp[5:0]};
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/utf8_classify.sv
// ============================================================================
//  Module      : utf8_classify
//  Description : Combinational classifier: code point -> {valid, length,
//                lead byte}. Shareable with the decoder for overlong checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module utf8_classify
    import utf8_pkg::*;
#(
    parameter int ALLOW_SURROGATES = 0
) (
    input  logic [20:0] cp,
    output logic        valid,
    output len_t        length,
    output logic [7:0]  lead_byte
);

    logic w_is_surrogate;

    assign w_is_surrogate = (cp >= SURROGATE_LO) && (cp <= SURROGATE_HI);

    always_comb begin
        valid     = 1'b1;
        length    = LEN_1;
        lead_byte = {1'b0, cp[6:0]};

        if (cp <= MAX_1BYTE) begin
            length    = LEN_1;
            lead_byte = {1'b0, cp[6:0]};
        end else if (cp <= MAX_2BYTE) begin
            length    = LEN_2;
            lead_byte = LEAD_2 | {3'b000, cp[10:6]};
        end else if (cp <= MAX_3BYTE) begin
            length    = LEN_3;
            lead_byte = LEAD_3 | {4'b0000, cp[15:12]};
            if ((ALLOW_SURROGATES == 0) && w_is_surrogate) begin
                valid = 1'b0;
            end
        end else if (cp <= MAX_CODE_POINT) begin
            length    = LEN_4;
            lead_byte = LEAD_4 | {5'b00000, cp[20:18]};
        end else begin
            valid = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/utf8_encoder.sv
// ============================================================================
//  Module      : utf8_encoder
//  Description : Serialises one Unicode scalar value into 1..4 UTF-8 bytes
//                over a byte-wide valid/ready stream, lead byte first.
//                Optional macro UTF8_ENCODER_REPLACEMENT_EN substitutes
//                U+FFFD for unencodable code points instead of flagging them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module utf8_encoder
    import utf8_pkg::*;
#(
    parameter int ALLOW_SURROGATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        allow,
    input  logic [20:0] code_point,
    output logic        accept,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [1:0]  status
);

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_EMIT = 1'b1;

    logic [0:0]  r_state;
    logic        r_accept;
    logic [7:0]  r_byte;
    logic        r_valid;
    logic [1:0]  r_status;
    len_t        r_remaining;
    logic [17:0] r_cp;

    logic        w_raw_valid;
    len_t        w_raw_len;
    logic [7:0]  w_raw_lead;

    logic        w_enc_ok;
    len_t        w_enc_len;
    logic [7:0]  w_enc_lead;
    logic [17:0] w_enc_cp;

    utf8_classify #(
        .ALLOW_SURROGATES (ALLOW_SURROGATES)
    ) u_classify (
        .cp        (code_point),
        .valid     (w_raw_valid),
        .length    (w_raw_len),
        .lead_byte (w_raw_lead)
    );

`ifdef UTF8_ENCODER_REPLACEMENT_EN
    // Unencodable input is silently swapped for U+FFFD (EF BF BD).
    assign w_enc_ok   = 1'b1;
    assign w_enc_len  = w_raw_valid ? w_raw_len  : LEN_3;
    assign w_enc_lead = w_raw_valid ? w_raw_lead
                                    : (LEAD_3 | {4'b0000, REPLACEMENT_CHAR[15:12]});
    assign w_enc_cp   = w_raw_valid ? code_point[17:0] : REPLACEMENT_CHAR[17:0];
`else
    assign w_enc_ok   = w_raw_valid;
    assign w_enc_len  = w_raw_len;
    assign w_enc_lead = w_raw_lead;
    assign w_enc_cp   = code_point[17:0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= C_ST_IDLE;
            r_accept    <= 1'b1;
            r_byte      <= 8'h00;
            r_valid     <= 1'b0;
            r_status    <= STATUS_IDLE;
            r_remaining <= LEN_1;
            r_cp        <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (allow && r_accept) begin
                        if (w_enc_ok) begin
                            r_state     <= C_ST_EMIT;
                            r_accept    <= 1'b0;
                            r_byte      <= w_enc_lead;
                            r_valid     <= 1'b1;
                            r_status    <= STATUS_BUSY;
                            r_remaining <= w_enc_len;
                            r_cp        <= w_enc_cp;
                        end else begin
                            // Sticky until the next accepted code point
                            r_status <= STATUS_ERROR;
                        end
                    end
                end

                C_ST_EMIT: begin
                    if (r_valid && byte_ready) begin
                        if (r_remaining != LEN_1) begin
                            r_byte      <= cont_byte(r_cp, r_remaining);
                            r_remaining <= r_remaining - 2'd1;
                        end else begin
                            r_state  <= C_ST_IDLE;
                            r_accept <= 1'b1;
                            r_valid  <= 1'b0;
                            r_status <= STATUS_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign accept     = r_accept;
    assign byte_data  = r_byte;
    assign byte_valid = r_valid;
    assign status     = r_status;

endmodule

`default_nettype wire

// File: tb/tb_utf8_encoder.sv
// ============================================================================
//  Module      : tb_utf8_encoder
//  Description : Directed self-checking bench for utf8_encoder (default build,
//                plus a second instance with surrogates allowed).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_utf8_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        allow;
    logic [20:0] code_point;
    logic        accept;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [1:0]  status;

    logic        s_allow;
    logic [20:0] s_code_point;
    logic        s_accept;
    logic [7:0]  s_byte_data;
    logic        s_byte_valid;
    logic        s_byte_ready;
    logic [1:0]  s_status;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    utf8_encoder #(.ALLOW_SURROGATES(0)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .allow      (allow),
        .code_point (code_point),
        .accept     (accept),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .status     (status)
    );

    utf8_encoder #(.ALLOW_SURROGATES(1)) u_dut_sur (
        .clock      (clock),
        .reset      (reset),
        .allow      (s_allow),
        .code_point (s_code_point),
        .accept     (s_accept),
        .byte_data  (s_byte_data),
        .byte_valid (s_byte_valid),
        .byte_ready (s_byte_ready),
        .status     (s_status)
    );

    // Handshake only; returns at the first negedge after the transfer edge.
    task automatic drive_cp(input logic [20:0] cp);
        int n;
        n = 0;
        @(negedge clock);
        allow      = 1'b1;
        code_point = cp;
        while (accept !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            fails++;
            $display("FAIL handshake_timeout: accept=%b for cp=%h, required 1", accept, cp);
        end
        @(negedge clock);
        allow      = 1'b0;
        code_point = 21'h1FFFFF;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        allow        = 1'b0;
        code_point   = '0;
        byte_ready   = 1'b1;
        s_allow      = 1'b0;
        s_code_point = '0;
        s_byte_ready = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (accept !== 1'b1) begin fails++; $display("FAIL reset_accept: got %b, required 1", accept); end
        checks++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", byte_valid); end
        checks++; if (byte_data !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h, required 00", byte_data); end
        checks++; if (status !== 2'b00) begin fails++; $display("FAIL reset_status: got %b, required 00", status); end
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        byte_ready = 1'b1;
        drive_cp(21'h41);
        checks++; if ({byte_valid, byte_data} !== {1'b1, 8'h41}) begin fails++; $display("FAIL single_byte: got v=%b b=%h, required v=1 b=41", byte_valid, byte_data); end
        checks++; if (status !== 2'b01) begin fails++; $display("FAIL single_status_busy: got %b, required 01", status); end
        checks++; if (accept !== 1'b0) begin fails++; $display("FAIL single_accept_low: got %b, required 0", accept); end
        @(negedge clock);
        checks++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL single_end_valid: got %b, required 0", byte_valid); end
        checks++; if (accept !== 1'b1) begin fails++; $display("FAIL single_end_accept: got %b, required 1", accept); end
        checks++; if (status !== 2'b00) begin fails++; $display("FAIL single_end_status: got %b, required 00", status); end
    endtask

    task automatic test_multi_byte();
        logic [20:0] cps  [3] = '{21'h0000E9, 21'h0020AC, 21'h01F600};
        int          lens [3] = '{2, 3, 4};
        logic [7:0]  exp  [3][4] = '{'{8'hC3, 8'hA9, 8'h00, 8'h00},
                                     '{8'hE2, 8'h82, 8'hAC, 8'h00},
                                     '{8'hF0, 8'h9F, 8'h98, 8'h80}};
        byte_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            drive_cp(cps[t]);
            for (int k = 0; k < lens[t]; k++) begin
                checks++; if ({byte_valid, byte_data} !== {1'b1, exp[t][k]}) begin fails++; $display("FAIL multi_byte cp=%h idx=%0d: got v=%b b=%h, required v=1 b=%h", cps[t], k, byte_valid, byte_data, exp[t][k]); end
                checks++; if (status !== 2'b01 || accept !== 1'b0) begin fails++; $display("FAIL multi_busy cp=%h idx=%0d: got st=%b acc=%b, required st=01 acc=0", cps[t], k, status, accept); end
                @(negedge clock);
            end
            checks++; if ({byte_valid, accept, status} !== {1'b0, 1'b1, 2'b00}) begin fails++; $display("FAIL multi_end cp=%h: got v=%b acc=%b st=%b, required v=0 acc=1 st=00", cps[t], byte_valid, accept, status); end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp [3] = '{8'hE2, 8'h82, 8'hAC};
        byte_ready = 1'b0;
        drive_cp(21'h0020AC);
        for (int k = 0; k < 3; k++) begin
            for (int h = 0; h < 4; h++) begin
                checks++; if ({byte_valid, byte_data, accept} !== {1'b1, exp[k], 1'b0}) begin fails++; $display("FAIL stall idx=%0d hold=%0d: got v=%b b=%h acc=%b, required v=1 b=%h acc=0", k, h, byte_valid, byte_data, accept, exp[k]); end
                if (h < 3) @(negedge clock);
            end
            byte_ready = 1'b1;
            @(negedge clock);
            byte_ready = 1'b0;
        end
        checks++; if ({byte_valid, accept, status} !== {1'b0, 1'b1, 2'b00}) begin fails++; $display("FAIL stall_end: got v=%b acc=%b st=%b, required v=0 acc=1 st=00", byte_valid, accept, status); end
        byte_ready = 1'b1;
    endtask

    task automatic test_invalid();
        byte_ready = 1'b1;
        drive_cp(21'h00D800);
        checks++; if ({byte_valid, accept, status} !== {1'b0, 1'b1, 2'b10}) begin fails++; $display("FAIL invalid_surrogate: got v=%b acc=%b st=%b, required v=0 acc=1 st=10", byte_valid, accept, status); end
        repeat (3) @(negedge clock);
        checks++; if ({byte_valid, status} !== {1'b0, 2'b10}) begin fails++; $display("FAIL invalid_sticky: got v=%b st=%b, required v=0 st=10", byte_valid, status); end
        drive_cp(21'h00DFFF);
        checks++; if ({byte_valid, status} !== {1'b0, 2'b10}) begin fails++; $display("FAIL invalid_surrogate_hi: got v=%b st=%b, required v=0 st=10", byte_valid, status); end
        drive_cp(21'h110000);
        checks++; if ({byte_valid, status} !== {1'b0, 2'b10}) begin fails++; $display("FAIL invalid_range: got v=%b st=%b, required v=0 st=10", byte_valid, status); end
        drive_cp(21'h41);
        checks++; if ({byte_valid, byte_data, status} !== {1'b1, 8'h41, 2'b01}) begin fails++; $display("FAIL invalid_recover: got v=%b b=%h st=%b, required v=1 b=41 st=01", byte_valid, byte_data, status); end
        @(negedge clock);
        checks++; if ({byte_valid, status} !== {1'b0, 2'b00}) begin fails++; $display("FAIL invalid_recover_end: got v=%b st=%b, required v=0 st=00", byte_valid, status); end
    endtask

    task automatic test_boundaries();
        logic [20:0] cps  [9] = '{21'h00007F, 21'h000080, 21'h0007FF, 21'h000800, 21'h00FFFF,
                                  21'h010000, 21'h10FFFF, 21'h00D7FF, 21'h00E000};
        int          lens [9] = '{1, 2, 2, 3, 3, 4, 4, 3, 3};
        logic [7:0]  exp  [9][4] = '{'{8'h7F, 8'h00, 8'h00, 8'h00},
                                     '{8'hC2, 8'h80, 8'h00, 8'h00},
                                     '{8'hDF, 8'hBF, 8'h00, 8'h00},
                                     '{8'hE0, 8'hA0, 8'h80, 8'h00},
                                     '{8'hEF, 8'hBF, 8'hBF, 8'h00},
                                     '{8'hF0, 8'h90, 8'h80, 8'h80},
                                     '{8'hF4, 8'h8F, 8'hBF, 8'hBF},
                                     '{8'hED, 8'h9F, 8'hBF, 8'h00},
                                     '{8'hEE, 8'h80, 8'h80, 8'h00}};
        byte_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            drive_cp(cps[t]);
            for (int k = 0; k < lens[t]; k++) begin
                checks++; if ({byte_valid, byte_data} !== {1'b1, exp[t][k]}) begin fails++; $display("FAIL boundary cp=%h idx=%0d: got v=%b b=%h, required v=1 b=%h", cps[t], k, byte_valid, byte_data, exp[t][k]); end
                @(negedge clock);
            end
            checks++; if ({byte_valid, accept} !== {1'b0, 1'b1}) begin fails++; $display("FAIL boundary_end cp=%h: got v=%b acc=%b, required v=0 acc=1", cps[t], byte_valid, accept); end
        end
    endtask

    task automatic test_reset_mid_sequence();
        byte_ready = 1'b1;
        drive_cp(21'h01F600);
        checks++; if (byte_data !== 8'hF0) begin fails++; $display("FAIL midreset_b0: got %h, required F0", byte_data); end
        @(negedge clock);
        checks++; if (byte_data !== 8'h9F) begin fails++; $display("FAIL midreset_b1: got %h, required 9F", byte_data); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({byte_valid, accept, status, byte_data} !== {1'b0, 1'b1, 2'b00, 8'h00}) begin fails++; $display("FAIL midreset_state: got v=%b acc=%b st=%b b=%h, required v=0 acc=1 st=00 b=00", byte_valid, accept, status, byte_data); end
        reset = 1'b0;
        drive_cp(21'h41);
        checks++; if ({byte_valid, byte_data} !== {1'b1, 8'h41}) begin fails++; $display("FAIL midreset_next: got v=%b b=%h, required v=1 b=41", byte_valid, byte_data); end
        @(negedge clock);
        checks++; if ({byte_valid, accept} !== {1'b0, 1'b1}) begin fails++; $display("FAIL midreset_next_end: got v=%b acc=%b, required v=0 acc=1", byte_valid, accept); end
    endtask

    task automatic test_surrogate_allowed();
        logic [7:0] exp [3] = '{8'hED, 8'hA0, 8'h80};
        int n;
        n = 0;
        s_byte_ready = 1'b1;
        @(negedge clock);
        s_allow      = 1'b1;
        s_code_point = 21'h00D800;
        while (s_accept !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            fails++;
            $display("FAIL sur_handshake_timeout: accept=%b, required 1", s_accept);
        end
        @(negedge clock);
        s_allow      = 1'b0;
        s_code_point = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({s_byte_valid, s_byte_data} !== {1'b1, exp[k]}) begin fails++; $display("FAIL surrogate_allowed idx=%0d: got v=%b b=%h, required v=1 b=%h", k, s_byte_valid, s_byte_data, exp[k]); end
            @(negedge clock);
        end
        checks++; if ({s_byte_valid, s_status} !== {1'b0, 2'b00}) begin fails++; $display("FAIL surrogate_allowed_end: got v=%b st=%b, required v=0 st=00", s_byte_valid, s_status); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_back_pressure();
        test_invalid();
        test_boundaries();
        test_reset_mid_sequence();
        test_surrogate_allowed();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
